keystream_gen: RTL

KEYSTREAM_GEN -- requirements
Module: keystream_gen

---
 rtl/keystream_gen.sv | 87 ++++++++
 1 files changed

// File: rtl/keystream_gen.sv
// 32-bit Fibonacci LFSR keystream generator: 8 LFSR steps per byte, then the
// byte is held under a valid/ready handshake until the downstream stage takes it.
module keystream_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid_i,
  input  logic [31:0] seed_i,
  output logic        ks_valid_o,
  input  logic        ks_ready_i,
  output logic [7:0]  ks_data_o,
  output logic        busy_o,
  output logic [15:0] ks_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, VALID} state_t;

  state_t      r_state;
  logic [31:0] r_lfsr;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_data;
  logic [15:0] r_count;
  logic        r_valid;
  logic        r_busy;

  logic        w_fb;
  logic [31:0] w_next;
  logic [31:0] w_seed;

  assign w_fb   = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
  assign w_next = {r_lfsr[30:0], w_fb};
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed = (seed_i == 32'h0) ? 32'h1 : seed_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lfsr   <= 32'h1;
      r_bitcnt <= 3'd0;
      r_data   <= 8'h00;
      r_count  <= 16'h0000;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (seed_valid_i) begin
      // A load aborts any byte in flight; a coinciding transfer is dropped from the count.
      r_state  <= RUN;
      r_lfsr   <= w_seed;
      r_bitcnt <= 3'd0;
      r_count  <= 16'h0000;
      r_valid  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: ;
        RUN: begin
          r_lfsr   <= w_next;
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_data  <= w_next[7:0];
            r_state <= VALID;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        VALID: begin
          if (ks_ready_i) begin
            r_count  <= r_count + 16'd1;
            r_bitcnt <= 3'd0;
            r_state  <= RUN;
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ks_valid_o = r_valid;
  assign busy_o     = r_busy;
  assign ks_data_o  = r_data;
  assign ks_count_o = r_count;

endmodule
